// File: rtl/reset_sequencer.sv
// -----------------------------------------------------------------------------
// reset_sequencer
//
// Multi-channel reset controller for core-clock logic. An asynchronous
// active-high reset is synchronised (async assert, sync deassert), all channel
// resets are held for HOLD_CYCLES, then the NUM_CH channel resets are released
// one after another, STAGGER_CYCLES apart, starting with channel 0. At run time
// the whole sequence can be re-run (iGlobalReq) and individual channels can be
// put through a soft reset of HOLD_CYCLES (iSoftReq).
//
// Optional feature: define RST_SEQ_EVENT_CNT_EN to build a saturating 16-bit
// count of completed sequences on oEventCnt; otherwise oEventCnt is 16'h0000.
//
// Ports
//   Clock         in   1       core clock
//   qReset        in   1       async active-high reset
//   iGlobalReq    in   1       sync pulse, re-run the full sequence
//   iSoftReq      in   NUM_CH  sync per-channel soft reset request
//   oChReset      out  NUM_CH  active-high channel resets, bit 0 released first
//   oAllReleased  out  1       all channels out of reset
//   oBusy         out  1       a sequence or soft reset is in progress
//   oEventCnt     out  16      completed sequence count (optional)
// -----------------------------------------------------------------------------
module reset_sequencer #(
  parameter int SYNC_STAGES    = 8,
  parameter int NUM_CH         = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4
) (
  input  logic              Clock,
  input  logic              qReset,
  input  logic              iGlobalReq,
  input  logic [NUM_CH-1:0] iSoftReq,
  output logic [NUM_CH-1:0] oChReset,
  output logic              oAllReleased,
  output logic              oBusy,
  output logic [15:0]       oEventCnt
);

  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int SW = $clog2(STAGGER_CYCLES + 1);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
  localparam logic [SW-1:0] STAG_LAST = SW'(STAGGER_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CH - 1);

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [SYNC_STAGES-1:0]      sync_q, sync_d;
  logic [HW-1:0]               hold_cnt_q, hold_cnt_d;
  logic [SW-1:0]               stag_cnt_q, stag_cnt_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [IW-1:0]               idx_nxt;
  logic [NUM_CH-1:0]           ch_q, ch_d;
  logic [NUM_CH-1:0][HW-1:0]   soft_cnt_q, soft_cnt_d;
  logic                        all_rel_q, all_rel_d;
  logic                        busy_q, busy_d;
  logic                        rst_sync;

  assign rst_sync = sync_q[SYNC_STAGES-1];
  assign sync_d   = {sync_q[SYNC_STAGES-2:0], 1'b0};
  assign idx_nxt  = idx_q + IW'(1);

  // Next-state logic for the sequencing FSM, hold/stagger counters and soft resets.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    stag_cnt_d = stag_cnt_q;
    idx_d      = idx_q;
    ch_d       = ch_q;
    soft_cnt_d = soft_cnt_q;
    case (state_q)
      ST_HOLD: begin
        ch_d = {NUM_CH{1'b1}};
        if (rst_sync || iGlobalReq) begin
          hold_cnt_d = {HW{1'b0}};
        end else if (hold_cnt_q == HOLD_LAST) begin
          // Channel 0 is released on the same edge the hold period ends.
          hold_cnt_d = {HW{1'b0}};
          stag_cnt_d = {SW{1'b0}};
          idx_d      = {IW{1'b0}};
          ch_d[0]    = 1'b0;
          if (NUM_CH == 1) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      ST_RELEASE: begin
        if (iGlobalReq) begin
          state_d    = ST_HOLD;
          hold_cnt_d = {HW{1'b0}};
          ch_d       = {NUM_CH{1'b1}};
          soft_cnt_d = '0;
        end else if (stag_cnt_q == STAG_LAST) begin
          stag_cnt_d    = {SW{1'b0}};
          idx_d         = idx_nxt;
          ch_d[idx_nxt] = 1'b0;
          if (idx_nxt == IDX_LAST) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_RELEASE;
          end
        end else begin
          stag_cnt_d = stag_cnt_q + SW'(1);
        end
      end
      ST_RUN: begin
        if (iGlobalReq) begin
          // Global request wins; any soft request in the same cycle is dropped.
          state_d    = ST_HOLD;
          hold_cnt_d = {HW{1'b0}};
          ch_d       = {NUM_CH{1'b1}};
          soft_cnt_d = '0;
        end else begin
          for (int i = 0; i < NUM_CH; i++) begin
            if (iSoftReq[i]) begin
              soft_cnt_d[i] = HOLD_LOAD;
              ch_d[i]       = 1'b1;
            end else if (soft_cnt_q[i] == HW'(1)) begin
              soft_cnt_d[i] = {HW{1'b0}};
              ch_d[i]       = 1'b0;
            end else if (soft_cnt_q[i] != {HW{1'b0}}) begin
              soft_cnt_d[i] = soft_cnt_q[i] - HW'(1);
            end else begin
              soft_cnt_d[i] = soft_cnt_q[i];
            end
          end
        end
      end
      default: begin
        state_d    = ST_HOLD;
        hold_cnt_d = {HW{1'b0}};
        ch_d       = {NUM_CH{1'b1}};
        soft_cnt_d = '0;
      end
    endcase
  end

  // Released only once RUN has been held for an edge, so the flag trails the last channel by one edge.
  assign all_rel_d = (state_q == ST_RUN) && (state_d == ST_RUN) && (soft_cnt_d == '0);
  assign busy_d    = ~all_rel_d;

  // State, synchroniser and output registers; qReset forces the reset values asynchronously.
  always_ff @(posedge Clock or posedge qReset) begin
    if (qReset) begin
      state_q    <= ST_HOLD;
      sync_q     <= {SYNC_STAGES{1'b1}};
      hold_cnt_q <= {HW{1'b0}};
      stag_cnt_q <= {SW{1'b0}};
      idx_q      <= {IW{1'b0}};
      ch_q       <= {NUM_CH{1'b1}};
      soft_cnt_q <= '0;
      all_rel_q  <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      hold_cnt_q <= hold_cnt_d;
      stag_cnt_q <= stag_cnt_d;
      idx_q      <= idx_d;
      ch_q       <= ch_d;
      soft_cnt_q <= soft_cnt_d;
      all_rel_q  <= all_rel_d;
      busy_q     <= busy_d;
    end
  end

  assign oChReset     = ch_q;
  assign oAllReleased = all_rel_q;
  assign oBusy        = busy_q;

`ifdef RST_SEQ_EVENT_CNT_EN
  logic [15:0] evt_cnt_q, evt_cnt_d;

  // Count entries into RUN, saturating at all ones; iGlobalReq does not clear it.
  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if ((state_q != ST_RUN) && (state_d == ST_RUN) && (evt_cnt_q != 16'hFFFF)) begin
      evt_cnt_d = evt_cnt_q + 16'd1;
    end else begin
      evt_cnt_d = evt_cnt_q;
    end
  end

  // Event counter register, cleared only by qReset.
  always_ff @(posedge Clock or posedge qReset) begin
    if (qReset) begin
      evt_cnt_q <= 16'h0000;
    end else begin
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign oEventCnt = evt_cnt_q;
`else
  assign oEventCnt = 16'h0000;
`endif

endmodule
